// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: sequences one register write or multi-byte register read per command
// over a byte-level I2C master handshake, with a per-wait watchdog.
module i2c_reg_seq #(
  parameter logic [6:0]  DEV_ADR = 7'h77,
  parameter int          MAX_LEN = 22,
  parameter logic [15:0] TIMEOUT = 16'hFFFF,
  localparam int         IW      = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_rw,
  input  logic [7:0]    cmd_reg,
  input  logic [7:0]    cmd_len,
  input  logic [7:0]    wr_data,
  output logic          wr_pop,
  input  logic [IW-1:0] rd_idx,
  output logic [7:0]    rd_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          isReady,
  output logic          start,
  output logic          send,
  output logic [7:0]    datasend,
  input  logic          sended,
  output logic          receive,
  input  logic [7:0]    datareceive,
  input  logic          received,
  output logic [3:0]    state
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, WAIT_READY = 4'd1, ADR_W = 4'd2, REG = 4'd3, WDATA = 4'd4,
    ADR_R = 4'd5, RECV = 4'd6, DONE = 4'd7, ERR = 4'd8
  } state_e;
  localparam logic [7:0] MAX_L = 8'(MAX_LEN);
  state_e      state_q, state_d;
  logic        rw_q, rw_d, err_q, err_d, last, stalled, wait_st;
  logic [7:0]  reg_q, reg_d, len_q, len_d, cnt_q, cnt_d;
  logic [15:0] wdog_q, wdog_d;
  logic [7:0]  buf_q [MAX_LEN];
  logic [7:0]  buf_d [MAX_LEN];
  assign wait_st = state_q inside {WAIT_READY, ADR_W, REG, WDATA, ADR_R, RECV};
  assign state   = state_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      reg_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
      buf_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      reg_q   <= reg_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      buf_q   <= buf_d;
    end
  end
  // cnt_q counts bytes already moved; it stops at len-1 so the buffer never wraps
  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    reg_d   = reg_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    last    = cnt_q == len_q - 8'd1;
    case (state_q)
      IDLE: if (cmd_valid) begin
        rw_d    = cmd_rw;
        reg_d   = cmd_reg;
        len_d   = cmd_len;
        cnt_d   = '0;
        state_d = (cmd_len == 8'd0 || cmd_len > MAX_L) ? ERR : WAIT_READY;
      end
      WAIT_READY: state_d = isReady ? ADR_W : WAIT_READY;
      ADR_W:      state_d = sended ? REG : ADR_W;
      REG:        state_d = sended ? (rw_q ? ADR_R : WDATA) : REG;
      WDATA: if (sended) begin
        state_d = last ? DONE : WDATA;
        cnt_d   = last ? cnt_q : cnt_q + 8'd1;
      end
      ADR_R:      state_d = sended ? RECV : ADR_R;
      RECV: if (received) begin
        buf_d[cnt_q[IW-1:0]] = datareceive;
        state_d = last ? DONE : RECV;
        cnt_d   = last ? cnt_q : cnt_q + 8'd1;
      end
      default:    state_d = IDLE;
    endcase
    stalled = wait_st && !sended && !received && state_d == state_q;
    if (stalled && wdog_q == TIMEOUT) state_d = ERR;
    wdog_d  = (stalled && wdog_q != TIMEOUT) ? wdog_q + 16'd1 : '0;
    err_d   = (state_d == ERR) || (err_q && !(state_q == IDLE && cmd_valid));
  end
  always_comb begin
    cmd_ready = state_q == IDLE;
    busy      = state_q != IDLE;
    start     = state_q == ADR_W || state_q == ADR_R;
    send      = start || state_q == REG || state_q == WDATA;
    receive   = state_q == RECV;
    wr_pop    = state_q == WDATA && sended;
    done      = state_q == DONE;
    err       = err_q;
    datasend  = state_q == ADR_W ? {DEV_ADR, 1'b0} :
                state_q == REG   ? reg_q :
                state_q == WDATA ? wr_data :
                state_q == ADR_R ? {DEV_ADR, 1'b1} : 8'h00;
    rd_data   = 32'(rd_idx) < MAX_LEN ? buf_q[rd_idx] : 8'h00;
  end
endmodule

// File: tb/tb_i2c_reg_seq.sv
// tb_i2c_reg_seq: table-driven commands against a cycle-level I2C master model,
// plus watchdog, illegal-length and mid-transfer reset sequences.
module tb_i2c_reg_seq;
  localparam logic [15:0] TO = 16'd40;
  logic clk = 1'b0, reset = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0, wr_pop, busy, done, err;
  logic [7:0] cmd_reg = '0, cmd_len = '0, wr_data = '0, rd_data, datasend, datareceive = '0;
  logic [4:0] rd_idx = '0;
  logic isReady = 1'b1, start, send, sended = 1'b0, receive, received = 1'b0;
  logic [3:0] state;

  i2c_reg_seq #(.DEV_ADR(7'h77), .MAX_LEN(22), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_reg(cmd_reg), .cmd_len(cmd_len), .wr_data(wr_data),
    .wr_pop(wr_pop), .rd_idx(rd_idx), .rd_data(rd_data), .busy(busy), .done(done),
    .err(err), .isReady(isReady), .start(start), .send(send), .datasend(datasend),
    .sended(sended), .receive(receive), .datareceive(datareceive),
    .received(received), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rw;
    logic [7:0] rg, ln, base;
    bit         e_err;
    int         e_nb;
    logic [7:0] e_b1, e_last;
  } vec_t;

  int pass_cnt = 0, tot_cnt = 0;
  logic [7:0] logb[$];
  bit logs[$];
  int ndone, npop, nrx, ncyc, cyc_done, cyc_last, fst_state, fst_err;
  bit act, rxw;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tot_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  task automatic run(input bit rw, input logic [7:0] rg, input logic [7:0] ln,
                     input logic [7:0] base, input int stall_at, input int rst_at,
                     input int budget);
    int d = 0;
    bit lastrx = 0;
    logb.delete(); logs.delete();
    ndone = 0; npop = 0; nrx = 0; ncyc = -1; cyc_done = -1; cyc_last = -1;
    act = 0; rxw = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_reg = rg; cmd_len = ln; wr_data = base;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (c == 0) begin
        cmd_valid = 1'b0; fst_state = int'(state); fst_err = int'(err);
      end
      sended = 1'b0; received = 1'b0;
      wr_data = 8'(base + npop);
      if (done) begin ndone++; cyc_done = c; end
      if (start || send || receive) act = 1;
      if (!rw && receive) rxw = 1;
      if (lastrx) chk("recv_fall", receive, 0);
      lastrx = 0;
      if (!busy || (rst_at > 0 && nrx == rst_at)) begin ncyc = c; break; end
      if (send && d == 0 && logb.size() != stall_at) begin
        logb.push_back(datasend); logs.push_back(start);
        sended = 1'b1; d = 1; cyc_last = c;
      end else if (receive && d == 0) begin
        datareceive = 8'(base + nrx); received = 1'b1; nrx++;
        d = 1; cyc_last = c; lastrx = (nrx == int'(ln));
      end else if (d > 0) d--;
      #1;
      if (wr_pop) npop++;
    end
    if (ncyc < 0) chk("bench_budget_expired", 0, 1);
  endtask

  task automatic chk_buf(input string nm, input logic [7:0] ln, input logic [7:0] base);
    int bad = 0;
    for (int i = 0; i < int'(ln); i++) begin
      rd_idx = 5'(i); #1;
      if (rd_data !== 8'(base + i)) bad++;
    end
    chk(nm, bad, 0);
  endtask

  vec_t tv[8];

  initial begin
    tv[0] = '{1'b1, 8'hD0, 8'd1,  8'h55, 1'b0, 3,  8'hD0, 8'hEF};
    tv[1] = '{1'b1, 8'hAA, 8'd22, 8'h00, 1'b0, 3,  8'hAA, 8'hEF};
    tv[2] = '{1'b0, 8'hF4, 8'd1,  8'h2E, 1'b0, 3,  8'hF4, 8'h2E};
    tv[3] = '{1'b0, 8'h10, 8'd3,  8'hA0, 1'b0, 5,  8'h10, 8'hA2};
    tv[4] = '{1'b1, 8'h11, 8'd0,  8'h00, 1'b1, 0,  8'h00, 8'h00};
    tv[5] = '{1'b1, 8'h12, 8'd23, 8'h00, 1'b1, 0,  8'h00, 8'h00};
    tv[6] = '{1'b0, 8'h20, 8'd22, 8'h40, 1'b0, 24, 8'h20, 8'h55};
    tv[7] = '{1'b1, 8'h33, 8'd2,  8'h90, 1'b0, 3,  8'h33, 8'hEF};

    #2;
    chk("rst_outputs", {start, send, receive, wr_pop, done, err, busy, datasend, state}, 0);
    chk("rst_rd_data", rd_data, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);

    for (int v = 0; v < 8; v++) begin
      if (v > 0 && tv[v-1].e_err) chk($sformatf("v%0d_err_sticky", v), err, 1);
      run(tv[v].rw, tv[v].rg, tv[v].ln, tv[v].base, -1, 0, 400);
      chk($sformatf("v%0d_done_cnt", v), ndone, tv[v].e_err ? 0 : 1);
      chk($sformatf("v%0d_err", v), err, tv[v].e_err);
      chk($sformatf("v%0d_nbytes", v), logb.size(), tv[v].e_nb);
      if (tv[v].e_err) begin
        chk($sformatf("v%0d_first_state", v), fst_state, 8);
        chk($sformatf("v%0d_first_err", v), fst_err, 1);
        chk($sformatf("v%0d_ready_at_T2", v), ncyc, 1);
        chk($sformatf("v%0d_no_activity", v), act, 0);
      end else begin
        chk($sformatf("v%0d_first_state", v), fst_state, 1);
        chk($sformatf("v%0d_first_err", v), fst_err, 0);
        chk($sformatf("v%0d_done_timing", v), cyc_done, cyc_last + 1);
        if (logb.size() >= 3) begin
          chk($sformatf("v%0d_byte0", v), logb[0], 8'hEE);
          chk($sformatf("v%0d_byte1", v), logb[1], tv[v].e_b1);
          chk($sformatf("v%0d_last_byte", v), logb[logb.size()-1], tv[v].e_last);
          chk($sformatf("v%0d_start_flags", v), {logs[0], logs[1], logs[2]}, {1'b1, 1'b0, tv[v].rw});
        end
        chk($sformatf("v%0d_pops", v), npop, tv[v].rw ? 0 : int'(tv[v].ln));
        chk($sformatf("v%0d_rx_cnt", v), nrx, tv[v].rw ? int'(tv[v].ln) : 0);
        chk($sformatf("v%0d_no_recv_on_write", v), rxw, 0);
        if (tv[v].rw) chk_buf($sformatf("v%0d_rd_buf", v), tv[v].ln, tv[v].base);
      end
    end

    rd_idx = 5'd2; #1;
    chk("buf_keep_old", rd_data, 8'h02);
    rd_idx = 5'd21; #1;
    chk("buf_last_entry", rd_data, 8'h15);
    rd_idx = 5'd31; #1;
    chk("rd_idx_out_of_range", rd_data, 0);

    isReady = 1'b0;
    run(1'b1, 8'hD0, 8'd1, 8'h00, -1, 0, int'(TO) + 20);
    chk("to_ready_err", err, 1);
    chk("to_ready_done", ndone, 0);
    chk("to_ready_no_activity", act, 0);
    chk("to_ready_window", (ncyc >= int'(TO) && ncyc <= int'(TO) + 4), 1);
    isReady = 1'b1;

    run(1'b1, 8'hD0, 8'd1, 8'h00, 1, 0, int'(TO) + 20);
    chk("to_reg_err", err, 1);
    chk("to_reg_done", ndone, 0);
    chk("to_reg_nbytes", logb.size(), 1);
    chk("to_reg_idle", state, 0);

    run(1'b1, 8'h3C, 8'd6, 8'h60, -1, 3, 200);
    chk("mid_recv_state", state, 6);
    rd_idx = 5'd2; #1;
    chk("mid_recv_byte2", rd_data, 8'h62);
    reset = 1'b0; #1;
    chk("async_rst_outputs", {start, send, receive, wr_pop, done, err, busy, datasend, state}, 0);
    begin
      int bad = 0;
      for (int i = 0; i < 32; i++) begin
        rd_idx = 5'(i); #1;
        if (rd_data !== 8'h00) bad++;
      end
      chk("async_rst_buf_clear", bad, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    run(1'b1, 8'hD0, 8'd1, 8'h55, -1, 0, 100);
    chk("post_rst_id_done", ndone, 1);
    chk("post_rst_id_err", err, 0);
    chk_buf("post_rst_id_buf", 8'd1, 8'h55);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
